// File: rtl/filtro_botoes_pkg.sv
// Purpose : shared FSM state encodings and the one-hot test for the button filter.
// Latency : n/a (types and a pure function only).
// Backpressure: n/a.
package filtro_botoes_pkg;

    localparam int N_BOTOES = 4;

    // Encodings are visible on db_estado, so the values are fixed explicitly.
    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        FILTRANDO   = 3'd1,
        PRESSIONADO = 3'd2,
        SOLTANDO    = 3'd3,
        IGNORADO    = 3'd4,
        INVALIDO    = 3'd5
    } estado_t;

    // True when exactly one bit is set (zero is not one-hot).
    function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/filtro_botoes_if.sv
// Purpose : bundles the button-side inputs and the clean play outputs of the filter.
// Latency : n/a (wiring only).
// Backpressure: none; outputs are level/strobe signals, the consumer must take them.
// Ports   : botoes_raw/habilita driven by master (board side); botoes, tem_jogada,
//           erro_multiplo, db_estado driven by slave (the filter).
interface filtro_botoes_if;
    import filtro_botoes_pkg::*;

    logic [N_BOTOES-1:0] botoes_raw;
    logic                habilita;
    logic [N_BOTOES-1:0] botoes;
    logic                tem_jogada;
    logic                erro_multiplo;
    logic [2:0]          db_estado;

    modport master (
        output botoes_raw,
        output habilita,
        input  botoes,
        input  tem_jogada,
        input  erro_multiplo,
        input  db_estado
    );

    modport slave (
        input  botoes_raw,
        input  habilita,
        output botoes,
        output tem_jogada,
        output erro_multiplo,
        output db_estado
    );

endinterface

// File: rtl/filtro_botoes_sincronizador_2ff.sv
// Purpose : W-bit two-flop synchronizer bringing asynchronous pins into the clock domain.
// Latency : 2 cycles from input to q.
// Backpressure: none.
// Ports   : clock, reset (async active-low), d (async in), q (synchronized out).
module sincronizador_2ff #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sinc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= d;
            sinc_q <= meta_q;
        end
    end

    assign q = sinc_q;

endmodule

// File: rtl/filtro_botoes.sv
// Purpose : debounces 4 raw buttons, rejects multi-button presses, emits one-hot play + strobe.
// Latency : stable press before edge k -> tem_jogada high after edge k+2+DEBOUNCE_CICLOS.
// Backpressure: none; habilita=0 at the accept point swallows the press instead of stalling.
// Ports   : clock, reset (async active-low), bus (filtro_botoes_if.slave).
module filtro_botoes
    import filtro_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int SOLTA_CICLOS    = 50000,
    parameter int N               = 16
) (
    input  logic           clock,
    input  logic           reset,
    filtro_botoes_if.slave bus
);

    localparam logic [N-1:0] DB_FIM    = N'(DEBOUNCE_CICLOS - 1);
    localparam logic [N-1:0] SOLTA_FIM = N'(SOLTA_CICLOS - 1);

    logic [N_BOTOES-1:0] s;

    sincronizador_2ff #(.W(N_BOTOES)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (bus.botoes_raw),
        .q     (s)
    );

    estado_t             estado_q, estado_d;
    logic [N_BOTOES-1:0] cand_q, cand_d;
    logic [N_BOTOES-1:0] s_ant_q, s_ant_d;
    logic [N-1:0]        cnt_q, cnt_d;
    logic [N_BOTOES-1:0] botoes_q, botoes_d;
    logic                tem_q, tem_d;
    logic                erro_q, erro_d;
    logic                limpa_cnt;
    logic                estavel;

    always_comb begin
        estado_d  = estado_q;
        cand_d    = cand_q;
        s_ant_d   = s;
        estavel   = (s == s_ant_q);
        // A change of s restarts any stability window.
        limpa_cnt = !estavel;

        unique case (estado_q)
            OCIOSO: begin
                if (eh_one_hot(s)) begin
                    estado_d = FILTRANDO;
                    cand_d   = s;
                end else if (s != '0) begin
                    estado_d = INVALIDO;
                end
            end
            FILTRANDO: begin
                if (s == '0) begin
                    estado_d = OCIOSO;
                end else if (!eh_one_hot(s)) begin
                    estado_d = INVALIDO;
                end else if (s != cand_q) begin
                    cand_d    = s;
                    limpa_cnt = 1'b1;
                end else if (estavel && cnt_q == DB_FIM) begin
                    estado_d = bus.habilita ? PRESSIONADO : IGNORADO;
                end
            end
            PRESSIONADO: begin
                if (s != cand_q) estado_d = SOLTANDO;
            end
            SOLTANDO: begin
                if (s == cand_q) begin
                    estado_d = PRESSIONADO;
                end else if (s == '0) begin
                    if (estavel && cnt_q == SOLTA_FIM) estado_d = OCIOSO;
                end else begin
                    limpa_cnt = 1'b1;
                end
            end
            IGNORADO, INVALIDO: begin
                if (s == '0 && estavel && cnt_q == SOLTA_FIM) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase

        if (limpa_cnt || estado_d != estado_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // All outputs are derived from the next state so they leave the flops glitch-free.
        tem_d    = (estado_q == FILTRANDO) && (estado_d == PRESSIONADO);
        erro_d   = (estado_d == INVALIDO);
        botoes_d = (estado_d == PRESSIONADO || estado_d == SOLTANDO) ? cand_d : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            cand_q   <= '0;
            s_ant_q  <= '0;
            cnt_q    <= '0;
            botoes_q <= '0;
            tem_q    <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cand_q   <= cand_d;
            s_ant_q  <= s_ant_d;
            cnt_q    <= cnt_d;
            botoes_q <= botoes_d;
            tem_q    <= tem_d;
            erro_q   <= erro_d;
        end
    end

    assign bus.botoes        = botoes_q;
    assign bus.tem_jogada    = tem_q;
    assign bus.erro_multiplo = erro_q;
    assign bus.db_estado     = estado_q;

endmodule

// File: tb/tb_filtro_botoes.sv
// Purpose : self-checking bench for filtro_botoes with a pulse scoreboard.
// Latency : expects tem_jogada 7 cycles after a clean raw press (DEBOUNCE=SOLTA=4).
// Backpressure: n/a.
module tb_filtro_botoes;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        int         ciclo;
        logic [3:0] cod;
    } esperado_t;

    esperado_t sb[$];

    filtro_botoes_if bus ();

    filtro_botoes #(
        .DEBOUNCE_CICLOS (4),
        .SOLTA_CICLOS    (4),
        .N               (4)
    ) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: obtido=%0h esperado=%0h (ciclo %0d)", tag, obs, esp, cyc);
        end
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive a raw code; when a pulse is due, record when and with which code.
    task automatic aplica(input logic [3:0] cod, input bit gera_pulso);
        bus.botoes_raw = cod;
        if (gera_pulso) sb.push_back('{ciclo: cyc + 7, cod: cod});
    endtask

    // Every observed pulse must match the head of the scoreboard exactly.
    always @(negedge clock) begin
        if (bus.tem_jogada === 1'b1) begin
            if (sb.size() == 0) begin
                verifica("pulso_inesperado", 32'd1, 32'd0);
            end else begin
                esperado_t e;
                e = sb.pop_front();
                verifica("pulso_ciclo", cyc, e.ciclo);
                verifica("pulso_cod", {28'd0, bus.botoes}, {28'd0, e.cod});
            end
        end
    end

    initial begin
        bus.botoes_raw = 4'b0000;
        bus.habilita   = 1'b1;
        espera(3);
        verifica("rst_botoes", {28'd0, bus.botoes}, 32'd0);
        verifica("rst_tem", {31'd0, bus.tem_jogada}, 32'd0);
        verifica("rst_erro", {31'd0, bus.erro_multiplo}, 32'd0);
        verifica("rst_estado", {29'd0, bus.db_estado}, 32'd0);
        rst_n = 1'b1;
        espera(2);

        // 1: clean press
        aplica(4'b0100, 1'b1);
        espera(10);
        verifica("t1_botoes", {28'd0, bus.botoes}, 32'h4);
        verifica("t1_estado", {29'd0, bus.db_estado}, 32'd2);
        aplica(4'b0000, 1'b0);
        espera(10);
        verifica("t1_solto", {28'd0, bus.botoes}, 32'd0);
        verifica("t1_ocioso", {29'd0, bus.db_estado}, 32'd0);

        // 2: bounce, then hold
        for (int i = 0; i < 6; i++) begin
            aplica((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
            espera(2);
        end
        verifica("t2_bounce_botoes", {28'd0, bus.botoes}, 32'd0);
        aplica(4'b0010, 1'b1);
        espera(10);
        verifica("t2_botoes", {28'd0, bus.botoes}, 32'h2);
        aplica(4'b0000, 1'b0);
        espera(10);

        // 3: multi-button press
        aplica(4'b0011, 1'b0);
        espera(4);
        verifica("t3_erro", {31'd0, bus.erro_multiplo}, 32'd1);
        verifica("t3_botoes", {28'd0, bus.botoes}, 32'd0);
        verifica("t3_estado", {29'd0, bus.db_estado}, 32'd5);
        aplica(4'b0000, 1'b0);
        espera(10);
        verifica("t3_erro_fim", {31'd0, bus.erro_multiplo}, 32'd0);
        verifica("t3_ocioso", {29'd0, bus.db_estado}, 32'd0);

        // 4: press swallowed while disabled, then accepted
        bus.habilita = 1'b0;
        aplica(4'b1000, 1'b0);
        espera(10);
        verifica("t4_ignorado", {29'd0, bus.db_estado}, 32'd4);
        verifica("t4_botoes0", {28'd0, bus.botoes}, 32'd0);
        aplica(4'b0000, 1'b0);
        espera(10);
        verifica("t4_ocioso", {29'd0, bus.db_estado}, 32'd0);
        bus.habilita = 1'b1;
        aplica(4'b1000, 1'b1);
        espera(10);
        verifica("t4_botoes", {28'd0, bus.botoes}, 32'h8);
        aplica(4'b0000, 1'b0);
        espera(10);

        // 5: release glitch returns to PRESSIONADO without a new pulse
        aplica(4'b0001, 1'b1);
        espera(10);
        aplica(4'b0000, 1'b0);
        espera(2);
        aplica(4'b0001, 1'b0);
        espera(1);
        verifica("t5_soltando", {29'd0, bus.db_estado}, 32'd3);
        verifica("t5_botoes_sol", {28'd0, bus.botoes}, 32'h1);
        espera(4);
        verifica("t5_pressionado", {29'd0, bus.db_estado}, 32'd2);
        verifica("t5_botoes_pre", {28'd0, bus.botoes}, 32'h1);
        aplica(4'b0000, 1'b0);
        espera(10);
        verifica("t5_solto", {28'd0, bus.botoes}, 32'd0);
        verifica("t5_ocioso", {29'd0, bus.db_estado}, 32'd0);

        // 6: reset while pressed, press still held afterwards
        aplica(4'b0100, 1'b1);
        espera(10);
        verifica("t6_pressionado", {29'd0, bus.db_estado}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        verifica("t6_rst_botoes", {28'd0, bus.botoes}, 32'd0);
        verifica("t6_rst_estado", {29'd0, bus.db_estado}, 32'd0);
        espera(2);
        rst_n = 1'b1;
        sb.push_back('{ciclo: cyc + 7, cod: 4'b0100});
        espera(10);
        verifica("t6_botoes", {28'd0, bus.botoes}, 32'h4);
        aplica(4'b0000, 1'b0);
        espera(10);

        verifica("pulsos_pendentes", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
